stream_packet_arbiter: RTL and testbench

STREAM_PACKET_ARBITER -- requirements
Module: stream_packet_arbiter

---
 rtl/stream_arb_pkg.sv | 17 +
 rtl/rr_select.sv | 33 +++
 rtl/stream_packet_arbiter.sv | 163 ++++++++++++++++
 tb/tb_stream_packet_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types and constants for the stream packet arbiter.
package stream_arb_pkg;

    // Arbiter FSM: waiting for a packet start, or locked onto one requester.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    // Wide enough for the largest supported requester count (16).
    localparam int GRANT_W = 4;
    typedef logic [GRANT_W-1:0] grant_idx_t;

    // Width of each per-requester packet counter (optional statistics).
    localparam int PKT_CNT_W = 32;

endpackage

// File: rtl/rr_select.sv
// Round-robin requester pick: the first set request bit scanning upward
// from (last_grant_i + 1) mod N_INPUTS with wrap. Purely combinational.
module rr_select
    import stream_arb_pkg::*;
#(
    parameter int N_INPUTS = 4
) (
    input  logic [N_INPUTS-1:0] req_i,
    input  grant_idx_t          last_grant_i,
    output grant_idx_t          idx_o,
    output logic                found_o
);

    // Walk the candidates in priority order; the inner loop turns the
    // computed candidate into a constant-index compare so no variable
    // bit-select of req_i is needed.
    always_comb begin
        int c;
        idx_o   = '0;
        found_o = 1'b0;
        c       = 0;
        for (int k = 1; k <= N_INPUTS; k++) begin
            c = (int'(last_grant_i) + k) % N_INPUTS;
            for (int j = 0; j < N_INPUTS; j++) begin
                if (!found_o && (j == c) && req_i[j]) begin
                    found_o = 1'b1;
                    idx_o   = grant_idx_t'(j);
                end
            end
        end
    end

endmodule

// File: rtl/stream_packet_arbiter.sv
// Packet-level round-robin arbiter merging N AXI4-Stream requesters into one
// registered output stream feeding a downstream FIFO. A packet is only
// started while the FIFO fill level is below FILL_THRESHOLD; once started it
// runs to tlast. Define STREAM_ARB_STATS_EN to add per-requester packet
// counters on o_pkt_count.
module stream_packet_arbiter
    import stream_arb_pkg::*;
#(
    parameter int N_INPUTS       = 4,
    parameter int DATA_WIDTH     = 512,
    parameter int FIFO_DEPTH     = 64,
    parameter int FILL_THRESHOLD = 48
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
`ifdef STREAM_ARB_STATS_EN
    output logic [N_INPUTS-1:0][PKT_CNT_W-1:0]      o_pkt_count,
`endif
    input  logic [N_INPUTS-1:0][DATA_WIDTH-1:0]     s_tdata,
    input  logic [N_INPUTS-1:0][DATA_WIDTH/8-1:0]   s_tkeep,
    input  logic [N_INPUTS-1:0]                     s_tlast,
    input  logic [N_INPUTS-1:0]                     s_tvalid,
    output logic [N_INPUTS-1:0]                     s_tready,
    output logic [DATA_WIDTH-1:0]                   o_data_tdata,
    output logic [DATA_WIDTH/8-1:0]                 o_data_tkeep,
    output logic                                    o_data_tlast,
    output logic                                    o_data_tvalid,
    input  logic                                    o_data_tready,
    input  logic [$clog2(FIFO_DEPTH):0]             i_filling_level,
    output logic [$clog2(N_INPUTS)-1:0]             o_grant,
    output logic                                    o_busy
);

    localparam int GW  = $clog2(N_INPUTS);
    localparam int KW  = DATA_WIDTH / 8;
    localparam int FLW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [FLW-1:0] FILL_THR = FLW'(FILL_THRESHOLD);

    arb_state_e          state_q, state_d;
    grant_idx_t          grant_q, grant_d;
    grant_idx_t          last_q, last_d;
    grant_idx_t          rr_idx;
    logic                rr_found;

    logic                sel_valid, sel_last;
    logic [DATA_WIDTH-1:0] sel_tdata;
    logic [KW-1:0]       sel_tkeep;
    logic                out_free, accept, start;

    logic                tvalid_q, tlast_q;
    logic [DATA_WIDTH-1:0] tdata_q;
    logic [KW-1:0]       tkeep_q;

    rr_select #(.N_INPUTS(N_INPUTS)) u_rr (
        .req_i        (s_tvalid),
        .last_grant_i (last_q),
        .idx_o        (rr_idx),
        .found_o      (rr_found)
    );

    // Output slot can take a beat when empty or being drained this cycle.
    assign out_free = !tvalid_q || o_data_tready;
    assign accept   = (state_q == LOCKED) && sel_valid && out_free;
    // Fill level only gates the start of a packet, never an ongoing one.
    assign start    = (state_q == IDLE) && rr_found && (i_filling_level < FILL_THR);

    // Granted-requester mux and ready fan-out; only the granted lane sees ready.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_tdata = '0;
        sel_tkeep = '0;
        s_tready  = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (grant_q == grant_idx_t'(i)) begin
                sel_valid   = s_tvalid[i];
                sel_last    = s_tlast[i];
                sel_tdata   = s_tdata[i];
                sel_tkeep   = s_tkeep[i];
                s_tready[i] = (state_q == LOCKED) && out_free;
            end
        end
    end

    // Next state: lock on a new grant, release after the accepted tlast beat.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOCKED;
                    grant_d = rr_idx;
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM and grant registers; last_q resets to the top index so lane 0 wins first.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= grant_idx_t'(N_INPUTS - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Single output register stage; payload holds while stalled downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
        end else if (accept) begin
            tvalid_q <= 1'b1;
            tdata_q  <= sel_tdata;
            tkeep_q  <= sel_tkeep;
            tlast_q  <= sel_last;
        end else if (o_data_tready) begin
            tvalid_q <= 1'b0;
        end
    end

    assign o_data_tvalid = tvalid_q;
    assign o_data_tdata  = tdata_q;
    assign o_data_tkeep  = tkeep_q;
    assign o_data_tlast  = tlast_q;
    assign o_grant       = grant_q[GW-1:0];
    assign o_busy        = (state_q == LOCKED);

`ifdef STREAM_ARB_STATS_EN
    logic [N_INPUTS-1:0][PKT_CNT_W-1:0] pkt_cnt_q;

    // Count completed packets per requester; wraps naturally at 2^32.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pkt_cnt_q <= '0;
        end else if (accept && sel_last) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (grant_q == grant_idx_t'(i)) begin
                    pkt_cnt_q[i] <= pkt_cnt_q[i] + PKT_CNT_W'(1);
                end
            end
        end
    end

    assign o_pkt_count = pkt_cnt_q;
`endif

endmodule

// File: tb/tb_stream_packet_arbiter.sv
// Self-checking bench: a directed vector table for arbitration order and
// fill gating, hand sequences for long packets, stalls and mid-packet reset,
// then randomized traffic checked against a queue-based packet model.
module tb_stream_packet_arbiter;

    localparam int N  = 4;
    localparam int DW = 32;
    localparam int KW = DW / 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N-1:0][DW-1:0] s_tdata;
    logic [N-1:0][KW-1:0] s_tkeep;
    logic [N-1:0]         s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]        o_tdata;
    logic [KW-1:0]        o_tkeep;
    logic                 o_tlast, o_tvalid, o_tready;
    logic [6:0]           fill;
    logic [1:0]           o_grant;
    logic                 o_busy;
`ifdef STREAM_ARB_STATS_EN
    logic [N-1:0][31:0]   pkt_count;
    logic [N-1:0][31:0]   cnt_tmp;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    stream_packet_arbiter #(
        .N_INPUTS(N), .DATA_WIDTH(DW), .FIFO_DEPTH(64), .FILL_THRESHOLD(48)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
`ifdef STREAM_ARB_STATS_EN
        .o_pkt_count     (pkt_count),
`endif
        .s_tdata         (s_tdata),
        .s_tkeep         (s_tkeep),
        .s_tlast         (s_tlast),
        .s_tvalid        (s_tvalid),
        .s_tready        (s_tready),
        .o_data_tdata    (o_tdata),
        .o_data_tkeep    (o_tkeep),
        .o_data_tlast    (o_tlast),
        .o_data_tvalid   (o_tvalid),
        .o_data_tready   (o_tready),
        .i_filling_level (fill),
        .o_grant         (o_grant),
        .o_busy          (o_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [3:0] vld;
        int         fl;
        logic [3:0] exp_rdy;
        logic       exp_busy;
        logic [1:0] exp_grant;
        logic       exp_ovld;
    } vec_t;
    vec_t tbl[13];

    // ---------------- packet-level reference model ----------------
    typedef struct {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
    } beat_t;

    beat_t      srcq[N][$];   // beats each requester still has to send
    beat_t      outq[$];      // beats accepted but not yet taken downstream
    logic [N-1:0] vld;        // requester is presenting its head beat
    bit         m_busy;
    int         m_g, m_last;
    int         pkt_id = 0;

    task automatic model_reset();
        m_busy = 1'b0;
        m_g    = 0;
        m_last = N - 1;
        outq.delete();
        for (int i = 0; i < N; i++) srcq[i].delete();
        vld = '0;
    endtask

    function automatic int rr_pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic push_pkt(input int src, input int len);
        beat_t bt;
        for (int b = 0; b < len; b++) begin
            bt.d = DW'((src << 24) | ((pkt_id & 'hfff) << 12) | b);
            bt.k = KW'($urandom_range(1, 15));
            bt.l = (b == len - 1);
            srcq[src].push_back(bt);
        end
        pkt_id++;
    endtask

    task automatic hard_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        s_tvalid = '0;
        s_tlast  = '0;
        o_tready = 1'b1;
        fill     = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    // One clock of traffic: drive, compare against the model, advance the model.
    task automatic step(input logic [N-1:0] want, input bit otr, input int fl, input bit rst);
        logic [N-1:0] exp_rdy;
        bit           ovm, take_in;
        beat_t        b;
        @(negedge clk);
        rst_n = !rst;
        for (int i = 0; i < N; i++) begin
            if (!vld[i] && want[i] && srcq[i].size() > 0) vld[i] = 1'b1;
            s_tvalid[i] = vld[i];
            if (vld[i]) begin
                s_tdata[i] = srcq[i][0].d;
                s_tkeep[i] = srcq[i][0].k;
                s_tlast[i] = srcq[i][0].l;
            end else begin
                s_tdata[i] = '0;
                s_tkeep[i] = '0;
                s_tlast[i] = 1'b0;
            end
        end
        o_tready = otr;
        fill     = 7'(fl);
        #1;
        ovm     = (outq.size() > 0);
        exp_rdy = '0;
        if (m_busy) exp_rdy[m_g] = !ovm || otr;
        chk("o_busy", o_busy, m_busy);
        chk("o_grant", o_grant, m_g);
        chk("s_tready", s_tready, exp_rdy);
        chk("o_tvalid", o_tvalid, ovm);
        if (ovm) begin
            chk("o_tdata", o_tdata, outq[0].d);
            chk("o_tkeep", o_tkeep, outq[0].k);
            chk("o_tlast", o_tlast, outq[0].l);
        end
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            take_in = m_busy && vld[m_g] && exp_rdy[m_g];
            if (ovm && otr) void'(outq.pop_front());
            if (take_in) begin
                b = srcq[m_g].pop_front();
                outq.push_back(b);
                vld[m_g] = 1'b0;
                if (b.l) begin
                    m_busy = 1'b0;
                    m_last = m_g;
                end
            end else if (!m_busy && vld != '0 && fl < 48) begin
                m_busy = 1'b1;
                m_g    = rr_pick(vld, m_last);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tlast  = '0;
        s_tvalid = '0;
        o_tready = 1'b1;
        fill     = '0;
        vld      = '0;

        //          vld     fill rdy     busy grant ovld
        tbl[0]  = '{4'b0101, 0, 4'b0000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{4'b0101, 0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{4'b0101, 0, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[3]  = '{4'b0101, 0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{4'b0101, 0, 4'b0000, 1'b0, 2'd2, 1'b1};
        tbl[5]  = '{4'b0101, 0, 4'b0001, 1'b1, 2'd0, 1'b0};
        tbl[6]  = '{4'b0101, 0, 4'b0000, 1'b0, 2'd0, 1'b1};
        tbl[7]  = '{4'b0101, 0, 4'b0100, 1'b1, 2'd2, 1'b0};
        tbl[8]  = '{4'b1111, 48, 4'b0000, 1'b0, 2'd2, 1'b1};
        tbl[9]  = '{4'b1111, 48, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[10] = '{4'b1111, 47, 4'b0000, 1'b0, 2'd2, 1'b0};
        tbl[11] = '{4'b1111, 47, 4'b1000, 1'b1, 2'd3, 1'b0};
        tbl[12] = '{4'b0000, 0, 4'b0000, 1'b0, 2'd3, 1'b1};

        // Reset state, with every requester valid so ready must stay low.
        s_tvalid = '1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_tvalid", o_tvalid, 1'b0);
        chk("rst_tdata", o_tdata, '0);
        chk("rst_busy", o_busy, 1'b0);
        chk("rst_grant", o_grant, 2'd0);
        chk("rst_tready", s_tready, 4'b0000);

        // Directed table: single-beat packets, round-robin order, fill gating.
        @(negedge clk);
        rst_n = 1'b1;
        for (int r = 0; r < 13; r++) begin
            if (r > 0) @(negedge clk);
            s_tvalid = tbl[r].vld;
            s_tlast  = '1;
            for (int i = 0; i < N; i++) begin
                s_tdata[i] = DW'(i);
                s_tkeep[i] = '1;
            end
            o_tready = 1'b1;
            fill     = 7'(tbl[r].fl);
            #1;
            chk($sformatf("tbl%0d_busy", r), o_busy, tbl[r].exp_busy);
            chk($sformatf("tbl%0d_grant", r), o_grant, tbl[r].exp_grant);
            chk($sformatf("tbl%0d_tready", r), s_tready, tbl[r].exp_rdy);
            chk($sformatf("tbl%0d_ovalid", r), o_tvalid, tbl[r].exp_ovld);
        end

        // Long packet from 1 while 3 waits: 5 contiguous beats, then 3.
        hard_reset();
        push_pkt(1, 5);
        push_pkt(3, 2);
        repeat (12) step(4'b1010, 1'b1, 0, 1'b0);
        chk("seq_a_drained", outq.size() + srcq[1].size() + srcq[3].size(), 0);

        // Downstream stall of 3 cycles mid-packet from requester 2.
        hard_reset();
        push_pkt(2, 4);
        repeat (2) step(4'b0100, 1'b1, 0, 1'b0);
        repeat (3) step(4'b0100, 1'b0, 60, 1'b0);
        repeat (6) step(4'b0100, 1'b1, 60, 1'b0);
        chk("seq_b_drained", outq.size() + srcq[2].size(), 0);

        // Reset at beat 3 of an 8-beat packet; lane 0 must win afterwards.
        hard_reset();
        push_pkt(1, 8);
        repeat (4) step(4'b0010, 1'b1, 0, 1'b0);
        step(4'b0010, 1'b1, 0, 1'b1);
        for (int i = 0; i < N; i++) push_pkt(i, 2);
        step(4'b1111, 1'b1, 0, 1'b0);
        step(4'b1111, 1'b1, 0, 1'b0);
        chk("seq_c_grant0", o_grant, 2'd0);
        chk("seq_c_busy", o_busy, 1'b1);
        repeat (10) step(4'b1111, 1'b1, 0, 1'b0);

        // Randomized traffic, backpressure, fill levels and occasional reset.
        hard_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            int fl;
            for (int i = 0; i < N; i++) begin
                if (srcq[i].size() == 0 && ($urandom % 4) == 0)
                    push_pkt(i, $urandom_range(1, 6));
            end
            fl = (($urandom % 8) == 0) ? $urandom_range(44, 64) : $urandom_range(0, 47);
            step(N'($urandom), ($urandom % 4) != 0, fl, ($urandom % 500) == 0);
        end

`ifdef STREAM_ARB_STATS_EN
        hard_reset();
        for (int p = 0; p < 3; p++) push_pkt(2, 2);
        repeat (14) step(4'b0100, 1'b1, 0, 1'b0);
        chk("cnt2_three", pkt_count[2], 32'd3);
        chk("cnt0_zero", pkt_count[0], 32'd0);
        chk("cnt1_zero", pkt_count[1], 32'd0);
        chk("cnt3_zero", pkt_count[3], 32'd0);
        @(negedge clk);
        cnt_tmp    = pkt_count;
        cnt_tmp[2] = 32'hffff_ffff;
        force dut.pkt_cnt_q = cnt_tmp;
        @(negedge clk);
        release dut.pkt_cnt_q;
        push_pkt(2, 1);
        repeat (4) step(4'b0100, 1'b1, 0, 1'b0);
        chk("cnt2_wrap", pkt_count[2], 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
